// File: rtl/cpu_ctl_fsm_if.sv
// Control bus between the accumulator-CPU sequencer and its datapath.
// The step input exists only when CPU_CTL_STEP_EN is defined.
interface cpu_ctl_fsm_if #(
  parameter int unsigned CNT_W = 16
);
`ifdef CPU_CTL_STEP_EN
  logic             step;
`endif
  logic             ena;
  logic [2:0]       opcode;
  logic             zero;
  logic             load_ir;
  logic             inc_pc;
  logic             load_pc;
  logic             rd;
  logic             wr;
  logic             datactl_ena;
  logic             con_alu;
  logic             load_acc;
  logic             halt;
  logic             busy;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
`ifdef CPU_CTL_STEP_EN
    output step,
`endif
    output ena, opcode, zero,
    input  load_ir, inc_pc, load_pc, rd, wr, datactl_ena, con_alu,
           load_acc, halt, busy, instr_cnt
  );

  modport slave (
`ifdef CPU_CTL_STEP_EN
    input  step,
`endif
    input  ena, opcode, zero,
    output load_ir, inc_pc, load_pc, rd, wr, datactl_ena, con_alu,
           load_acc, halt, busy, instr_cnt
  );
endinterface

// File: rtl/cpu_ctl_fsm.sv
// 8-cycle fetch/execute sequencer for the 8-bit accumulator CPU.
// Define CPU_CTL_STEP_EN to add single-step gating via the step input.
module cpu_ctl_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  cpu_ctl_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000, OP_SKZ = 3'b001, OP_ADD = 3'b010, OP_AND = 3'b011,
    OP_XOR = 3'b100, OP_LDA = 3'b101, OP_STO = 3'b110, OP_JMP = 3'b111
  } op_t;

  state_t           r_state;
  state_t           w_next;
  op_t              r_op_q;
  logic             r_zero_q;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             w_alu;
  logic             w_start;
  logic             w_load_ir, w_inc_pc, w_load_pc, w_rd, w_wr;
  logic             w_datactl_ena, w_con_alu, w_load_acc, w_halt, w_busy;

`ifdef CPU_CTL_STEP_EN
  assign w_start = bus.ena & bus.step;
`else
  assign w_start = bus.ena;
`endif

  assign w_alu = (r_op_q == OP_ADD) || (r_op_q == OP_AND) ||
                 (r_op_q == OP_XOR) || (r_op_q == OP_LDA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_op_q      <= OP_HLT;
      r_zero_q    <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_S2)
        r_op_q <= op_t'(bus.opcode);
      if ((r_state == ST_S5) && (r_op_q == OP_SKZ))
        r_zero_q <= bus.zero;
      if (r_state == ST_S7)
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_load_ir     = 1'b0;
    w_inc_pc      = 1'b0;
    w_load_pc     = 1'b0;
    w_rd          = 1'b0;
    w_wr          = 1'b0;
    w_datactl_ena = 1'b0;
    w_con_alu     = 1'b0;
    w_load_acc    = 1'b0;
    w_halt        = 1'b0;
    w_busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_start) w_next = ST_S0;
      end
      ST_S0: begin
        w_rd = 1'b1; w_load_ir = 1'b1; w_next = ST_S1;
      end
      ST_S1: begin
        w_rd = 1'b1; w_load_ir = 1'b1; w_inc_pc = 1'b1; w_next = ST_S2;
      end
      ST_S2: w_next = ST_S3;
      ST_S3: begin
        if (r_op_q == OP_HLT) begin
          w_halt = 1'b1; w_next = ST_HALTED;
        end else begin
          w_inc_pc = 1'b1; w_next = ST_S4;
        end
      end
      ST_S4: begin
        w_next = ST_S5;
        if (w_alu) begin
          w_rd = 1'b1; w_con_alu = 1'b1;
        end
        if (r_op_q == OP_STO) w_datactl_ena = 1'b1;
        if (r_op_q == OP_JMP) w_load_pc = 1'b1;
      end
      ST_S5: begin
        w_next = ST_S6;
        if (w_alu) begin
          w_rd = 1'b1; w_load_acc = 1'b1;
        end
        if (r_op_q == OP_STO) begin
          w_datactl_ena = 1'b1; w_wr = 1'b1;
        end
        if (r_op_q == OP_JMP) w_load_pc = 1'b1;
      end
      ST_S6: begin
        w_next = ST_S7;
        if (r_op_q == OP_STO) w_datactl_ena = 1'b1;
      end
      ST_S7: begin
        if ((r_op_q == OP_SKZ) && r_zero_q) w_inc_pc = 1'b1;
`ifdef CPU_CTL_STEP_EN
        w_next = ST_IDLE;
`else
        w_next = bus.ena ? ST_S0 : ST_IDLE;
`endif
      end
      ST_HALTED: begin
        w_busy = 1'b0; w_halt = 1'b1;
      end
      default: begin
        w_busy = 1'b0; w_next = ST_IDLE;
      end
    endcase
  end

  assign bus.load_ir     = w_load_ir;
  assign bus.inc_pc      = w_inc_pc;
  assign bus.load_pc     = w_load_pc;
  assign bus.rd          = w_rd;
  assign bus.wr          = w_wr;
  assign bus.datactl_ena = w_datactl_ena;
  assign bus.con_alu     = w_con_alu;
  assign bus.load_acc    = w_load_acc;
  assign bus.halt        = w_halt;
  assign bus.busy        = w_busy;
  assign bus.instr_cnt   = r_instr_cnt;

endmodule

// File: tb/tb_cpu_ctl_fsm.sv
// Scoreboard bench for cpu_ctl_fsm: a 16-bit and a 4-bit counter instance
// run in lockstep on shared stimulus.
module tb_cpu_ctl_fsm;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010,
                         STO = 3'b110, JMP = 3'b111;
  localparam int PH_IDLE = 8, PH_HALT = 9;

  typedef struct packed {
    logic busy, halt, load_acc, con_alu, datactl_ena, load_pc, wr, rd, inc_pc, load_ir;
  } strb_t;

  typedef struct {
    strb_t v;
    int    cnt;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       step = 1'b1;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   mcnt = 0;

  cpu_ctl_fsm_if #(.CNT_W(16)) bus16 ();
  cpu_ctl_fsm_if #(.CNT_W(4))  bus4 ();

  assign bus16.ena = ena;  assign bus16.opcode = opcode;  assign bus16.zero = zero;
  assign bus4.ena  = ena;  assign bus4.opcode  = opcode;  assign bus4.zero  = zero;
`ifdef CPU_CTL_STEP_EN
  assign bus16.step = step;
  assign bus4.step  = step;
`endif

  cpu_ctl_fsm #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus16));
  cpu_ctl_fsm #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic strb_t model(int ph, logic [2:0] op, logic zq);
    strb_t s;
    bit    alu;
    s   = '0;
    alu = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    s.busy = (ph <= 7);
    case (ph)
      0: begin s.rd = 1; s.load_ir = 1; end
      1: begin s.rd = 1; s.load_ir = 1; s.inc_pc = 1; end
      3: if (op == HLT) s.halt = 1; else s.inc_pc = 1;
      4: begin
        if (alu) begin s.rd = 1; s.con_alu = 1; end
        if (op == STO) s.datactl_ena = 1;
        if (op == JMP) s.load_pc = 1;
      end
      5: begin
        if (alu) begin s.rd = 1; s.load_acc = 1; end
        if (op == STO) begin s.datactl_ena = 1; s.wr = 1; end
        if (op == JMP) s.load_pc = 1;
      end
      6: if (op == STO) s.datactl_ena = 1;
      7: if (op == SKZ && zq) s.inc_pc = 1;
      PH_HALT: s.halt = 1;
      default: ;
    endcase
    return s;
  endfunction

  function automatic strb_t observe();
    strb_t s;
    s.busy = bus16.busy;       s.halt = bus16.halt;
    s.load_acc = bus16.load_acc; s.con_alu = bus16.con_alu;
    s.datactl_ena = bus16.datactl_ena; s.load_pc = bus16.load_pc;
    s.wr = bus16.wr;           s.rd = bus16.rd;
    s.inc_pc = bus16.inc_pc;   s.load_ir = bus16.load_ir;
    return s;
  endfunction

  task automatic push(input int ph, input logic [2:0] op, input logic zq, input string tag);
    exp_t e;
    e.v   = model(ph, op, zq);
    e.cnt = mcnt;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic run_cycles(input int n);
    exp_t  e;
    strb_t o;
    repeat (n) begin
      @(posedge clk);
      #1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: DUT cycle with no expectation queued");
      end else begin
        e = sb.pop_front();
        o = observe();
        if (o !== e.v) begin
          bad++;
          $display("FAIL %s strobes: got %b want %b", e.tag, o, e.v);
        end
        total++;
        if (bus16.instr_cnt !== 16'(e.cnt)) begin
          bad++;
          $display("FAIL %s cnt16: got %0d want %0d", e.tag, bus16.instr_cnt, 16'(e.cnt));
        end
        total++;
        if (bus4.instr_cnt !== 4'(e.cnt)) begin
          bad++;
          $display("FAIL %s cnt4: got %0d want %0d", e.tag, bus4.instr_cnt, 4'(e.cnt));
        end
      end
      total++;
      if (bus16.wr && (bus16.rd || bus16.load_ir)) begin
        bad++;
        $display("FAIL bus_excl: wr=%b rd=%b load_ir=%b", bus16.wr, bus16.rd, bus16.load_ir);
      end
    end
  endtask

  task automatic push_gap(input string tag);
`ifdef CPU_CTL_STEP_EN
    push(PH_IDLE, 3'b000, 1'b0, tag);
    run_cycles(1);
`endif
  endtask

  // Expects ena=1 with the FSM at an instruction boundary; when last, ena drops during S2.
  task automatic do_instr(input logic [2:0] op, input logic z, input bit last, input string tag);
    opcode = op;
    zero   = z;
    for (int ph = 0; ph < 8; ph++) push(ph, op, z, tag);
    mcnt++;
    run_cycles(3);
    if (last) ena = 1'b0;
    run_cycles(5);
    if (last) begin
      push(PH_IDLE, 3'b000, 1'b0, {tag, "_idle"});
      run_cycles(1);
    end else begin
      push_gap({tag, "_gap"});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (observe() !== strb_t'('0)) begin
      bad++;
      $display("FAIL %s strobes: got %b want %b", tag, observe(), strb_t'('0));
    end
    total++;
    if (bus16.instr_cnt !== 16'd0 || bus4.instr_cnt !== 4'd0) begin
      bad++;
      $display("FAIL %s cnt: got %0d/%0d want 0", tag, bus16.instr_cnt, bus4.instr_cnt);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst  = 1'b1;
    mcnt = 0;
    push(PH_IDLE, 3'b000, 1'b0, "idle_after_reset");
    push(PH_IDLE, 3'b000, 1'b0, "idle_after_reset");
    run_cycles(2);
  endtask

  task automatic test_add();
    ena = 1'b1;
    do_instr(ADD, 1'b0, 1'b0, "add1");
    do_instr(ADD, 1'b0, 1'b1, "add2");
  endtask

  task automatic test_skz();
    ena = 1'b1;
    do_instr(SKZ, 1'b1, 1'b0, "skz_z1");
    do_instr(SKZ, 1'b0, 1'b1, "skz_z0");
  endtask

  task automatic test_sto();
    ena = 1'b1;
    do_instr(STO, 1'b0, 1'b1, "sto");
  endtask

  task automatic test_ena_drop();
    ena = 1'b1;
    do_instr(JMP, 1'b0, 1'b1, "jmp_drop");
    push(PH_IDLE, 3'b000, 1'b0, "jmp_park");
    run_cycles(1);
    ena = 1'b1;
    do_instr(JMP, 1'b0, 1'b1, "jmp_resume");
  endtask

  task automatic test_hlt();
    ena    = 1'b1;
    opcode = HLT;
    for (int ph = 0; ph < 4; ph++) push(ph, HLT, 1'b0, "hlt");
    run_cycles(4);
    for (int i = 0; i < 20; i++) begin
      ena = ~ena;
      push(PH_HALT, HLT, 1'b0, "halted");
      run_cycles(1);
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("hlt_reset");
    mcnt = 0;
    ena  = 1'b0;
    #2 rst = 1'b1;
    push(PH_IDLE, 3'b000, 1'b0, "hlt_idle");
    run_cycles(1);
  endtask

  task automatic test_reset_midop();
    ena    = 1'b1;
    opcode = ADD;
    zero   = 1'b0;
    for (int ph = 0; ph < 6; ph++) push(ph, ADD, 1'b0, "add_abort");
    run_cycles(6);
    rst = 1'b0;
    #1;
    total++;
    if (bus16.load_acc !== 1'b0) begin
      bad++;
      $display("FAIL abort_load_acc: got %b want 0", bus16.load_acc);
    end
    check_reset_outputs("abort");
    mcnt = 0;
    ena  = 1'b0;
    #2 rst = 1'b1;
    push(PH_IDLE, 3'b000, 1'b0, "abort_idle");
    run_cycles(1);
  endtask

  task automatic test_wrap();
    ena = 1'b1;
    for (int i = 0; i < 16; i++) do_instr(ADD, 1'b0, (i == 15), "wrap");
    total++;
    if (bus4.instr_cnt !== 4'd0 || bus16.instr_cnt !== 16'd16) begin
      bad++;
      $display("FAIL wrap_cnt: got %0d/%0d want 0/16", bus4.instr_cnt, bus16.instr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_skz();
    test_sto();
    test_ena_drop();
    test_hlt();
    test_reset_midop();
    test_wrap();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
